// File: rtl/vx_wb_arbiter_pkg.sv
// Shared constants and helpers for the writeback arbiter slice.
// Select-width math lives here so every user sizes sel_out identically.
package vx_wb_arbiter_pkg;

   localparam int WB_NUM_EX_UNITS = 4;

   function automatic int wb_log_reqs(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_wb_arbiter_ebuf.sv
// Two-entry elastic buffer: a pushed beat is visible on valid_o the next cycle.
// ready_o drops only when both entries are full; head is held stable while ready_i is low.
module vx_wb_arbiter_ebuf #(
   parameter int DATAW = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [DATAW-1:0] data_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [DATAW-1:0] data_o
);

   logic [DATAW-1:0] mem_q [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             push, pop;

   assign ready_o = (count_q != 2'd2);
   assign valid_o = (count_q != 2'd0);
   assign data_o  = mem_q[rd_ptr_q];
   assign push    = valid_i && ready_o;
   assign pop     = valid_o && ready_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q ^ push;
      rd_ptr_d = rd_ptr_q ^ pop;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !push) begin
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset: entries are only read while count_q says they hold data.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/vx_wb_arbiter.sv
// Packet-atomic round-robin writeback arbiter; granted beats appear on valid_out 1 cycle later.
// ready_in follows the grant and the output buffer: a full buffer stalls every requester.
module vx_wb_arbiter
   import vx_wb_arbiter_pkg::*;
#(
   parameter int  NUM_REQS = WB_NUM_EX_UNITS,
   parameter int  DATAW    = 64,
   localparam int LOG_REQS = wb_log_reqs(NUM_REQS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQS-1:0]       valid_in,
   input  logic [NUM_REQS*DATAW-1:0] data_in,
   input  logic [NUM_REQS-1:0]       sop_in,
   input  logic [NUM_REQS-1:0]       eop_in,
   output logic [NUM_REQS-1:0]       ready_in,
   output logic                      valid_out,
   output logic [DATAW-1:0]          data_out,
   output logic                      sop_out,
   output logic                      eop_out,
   output logic [LOG_REQS-1:0]       sel_out,
   input  logic                      ready_out
);

   typedef enum logic {IDLE, LOCKED} state_e;

   localparam int BUFW = LOG_REQS + 2 + DATAW;

   state_e              state_q, state_d;
   logic [LOG_REQS-1:0] owner_q, owner_d;
   logic [LOG_REQS-1:0] rr_ptr_q, rr_ptr_d;
   logic [LOG_REQS-1:0] grant_idx, cand_idx;
   logic                grant_vld, accept, acc_sop, acc_eop;
   logic                buf_rdy, buf_vld;
   logic [BUFW-1:0]     buf_din, buf_dout;
   int                  cand;

   // A locked packet owns the output until its eop; otherwise search upward from rr_ptr.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = 0;
      cand_idx  = '0;
      if (state_q == LOCKED) begin
         grant_idx = owner_q;
         grant_vld = valid_in[owner_q];
      end else begin
         for (int k = 0; k < NUM_REQS; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQS) begin
               cand = cand - NUM_REQS;
            end
            cand_idx = cand[LOG_REQS-1:0];
            if (!grant_vld && valid_in[cand_idx]) begin
               grant_vld = 1'b1;
               grant_idx = cand_idx;
            end
         end
      end
   end

   assign acc_sop = sop_in[grant_idx];
   assign acc_eop = eop_in[grant_idx];
   assign accept  = grant_vld && buf_rdy && !reset;
   assign buf_din = {grant_idx, acc_sop, acc_eop, data_in[grant_idx*DATAW +: DATAW]};

   always_comb begin
      ready_in = '0;
      if (accept) begin
         ready_in[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         if (state_q == IDLE && acc_sop && !acc_eop) begin
            state_d = LOCKED;
            owner_d = grant_idx;
         end
         if (state_q == LOCKED && acc_eop) begin
            state_d = IDLE;
         end
         if (acc_eop) begin
            rr_ptr_d = (int'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   vx_wb_arbiter_ebuf #(
      .DATAW (BUFW)
   ) elastic_buffer (
      .clk     (clk),
      .reset   (reset),
      .valid_i (accept),
      .ready_o (buf_rdy),
      .data_i  (buf_din),
      .valid_o (buf_vld),
      .ready_i (ready_out),
      .data_o  (buf_dout)
   );

   // Buffered beats are flushed by reset, so the output is masked in that same cycle.
   assign valid_out = buf_vld && !reset;
   assign {sel_out, sop_out, eop_out, data_out} = buf_dout;

`ifdef SIMULATION
   always @(posedge clk) begin
      if (!reset) begin
         assert ($onehot0(ready_in)) else $error("ready_in not one-hot-or-zero");
         if (accept && state_q == LOCKED) begin
            assert (!acc_sop) else $error("sop from owner while locked");
         end
         if (accept && state_q == IDLE) begin
            assert (acc_sop) else $error("non-sop beat accepted while idle");
         end
      end
   end
`endif

endmodule

// File: doc/vx_wb_arbiter.md
VX_WB_ARBITER -- requirements
Module: VX_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of execution-unit writeback requesters (1..16).
REQ-002 SHALL have parameter DATAW, default 64, payload width per beat (wis, rd, PC, tmask, uuid, data packed by caller).
REQ-003 SHALL have parameter LOG_REQS, fixed at max(1, clog2(NUM_REQS)), width of sel_out.
REQ-004 SHALL have port clk, input, 1, single clock domain; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port valid_in, input, NUM_REQS, per-requester beat valid.
REQ-007 SHALL have port data_in, input, NUM_REQS x DATAW, per-requester payload.
REQ-008 SHALL have port sop_in, input, NUM_REQS, first beat of packet.
REQ-009 SHALL have port eop_in, input, NUM_REQS, last beat of packet.
REQ-010 SHALL have port ready_in, output, NUM_REQS, beat accepted when valid_in[i] && ready_in[i].
REQ-011 SHALL have port valid_out, output, 1, writeback beat valid toward scoreboard/regfile.
REQ-012 SHALL have port data_out, output, DATAW, granted payload.
REQ-013 SHALL have port sop_out, output, 1, forwarded sop.
REQ-014 SHALL have port eop_out, output, 1, forwarded eop; scoreboard releases rd on eop.
REQ-015 SHALL have port sel_out, output, LOG_REQS, index of source requester.
REQ-016 SHALL have port ready_out, input, 1, downstream accept.

Function
REQ-017 SHALL keep FSM with states IDLE (no owner) and LOCKED (owner register holds mid-packet requester).
REQ-018 In IDLE, SHALL grant round-robin among valid_in, searching from rr_ptr upward with wrap at NUM_REQS-1 -> 0.
REQ-019 SHALL assert ready_in only for the granted requester, and only when the output stage can accept; at most one ready_in bit high per cycle.
REQ-020 On accepted beat with sop && !eop, SHALL enter LOCKED with owner = granted index.
REQ-021 In LOCKED, SHALL grant only owner regardless of other valids; owner dropping valid_in SHALL produce bubbles, never a grant to another requester.
REQ-022 On accepted owner beat with eop, SHALL return to IDLE; a single-beat packet (sop && eop) SHALL never enter LOCKED.
REQ-023 On every accepted eop beat, SHALL set rr_ptr = (granted index + 1) mod NUM_REQS; rr_ptr SHALL NOT change on non-eop beats.
REQ-024 Output stage SHALL be a 2-entry skid buffer: accepted beat appears on valid_out exactly 1 cycle later; sustained 1 beat/cycle when ready_out held high.
REQ-025 With ready_out low, SHALL hold data_out/sop_out/eop_out/sel_out stable while valid_out is high; at most 2 beats are buffered, then all ready_in go low.
REQ-026 Beats SHALL exit in acceptance order; no beat dropped or duplicated.
REQ-027 NUM_REQS == 1 SHALL degenerate to registered pass-through with sel_out = 0.
REQ-028 In SIMULATION, SHALL assert on: sop from owner while LOCKED; non-sop beat accepted in IDLE; ready_in not one-hot-or-zero.

Reset
REQ-029 While reset is high: state = IDLE, rr_ptr = 0, both buffer entries empty, valid_out = 0, ready_in = 0; data_out/sop_out/eop_out/sel_out are don't-care.
REQ-030 Reset mid-packet SHALL discard lock and buffered beats; first cycle after reset SHALL arbitrate from requester 0.

Structure
REQ-031 SHALL define the FSM state enum locally; no new shared-package types; NUM_REQS bound at instantiation from NUM_EX_UNITS in VX_gpu_pkg.
REQ-032 SHALL instantiate VX_elastic_buffer (SIZE 2) as the one sub-module for the output stage; arbitration and lock logic reside in this module.

Verification
REQ-033 All 4 requesters valid with single-beat packets, ready_out = 1 -> sel_out sequence 0,1,2,3,0 on consecutive cycles starting 1 cycle after reset release.
REQ-034 Req1 sends 3-beat packet (sop, mid, eop) while req0/req2 valid -> sel_out = 1,1,1 contiguous, then next grant = 2.
REQ-035 Req1 locked, drops valid for 2 cycles mid-packet while req3 valid -> 2 bubbles on valid_out, req3 ready_in stays 0 until req1 eop accepted.
REQ-036 ready_out low 5 cycles under full load -> exactly 2 beats buffered, ready_in = 0, output stable; on release beats drain in order, no loss.
REQ-037 reset asserted while req2 is LOCKED with 1 beat buffered -> valid_out = 0 next cycle; after release, req0 granted first if valid.
REQ-038 Randomized valid/ready, packets 1-4 beats -> per-requester beat order preserved, packets never interleaved, scoreboard model sees each eop once.
